// File: rtl/fft_pkg.sv
// rtl/fft_pkg.sv - shared FFT result types, sizes and peak-reader state encoding
package fft_pkg;
  localparam int bit_width = 16;
  localparam int N         = 512;
  localparam int M         = 9;
  localparam int MIN_BIN   = 2;
  localparam int RAM_LAT   = 1;

  typedef logic signed [bit_width-1:0] sample_t;
  typedef logic [2*bit_width-1:0]      mag_t;
  typedef logic [M-1:0]                adr_t;
  typedef logic [M-2:0]                bin_t;

  typedef enum logic [1:0] {IDLE, SWEEP, DRAIN, DONE} state_t;
endpackage

// File: rtl/mag_sq.sv
// rtl/mag_sq.sv - pipelined re^2+im^2: registered squares, then an unregistered sum
// The sum stage is closed by the max-tracker register in the parent.
module mag_sq
  import fft_pkg::*;
(
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        i_valid,
  input  logic [M-2:0]                i_tag,
  input  logic signed [bit_width-1:0] i_re,
  input  logic signed [bit_width-1:0] i_im,
  output logic                        o_valid,
  output logic [M-2:0]                o_tag,
  output logic [2*bit_width-1:0]      o_sum
);
  logic signed [2*bit_width-1:0] w_re_x;
  logic signed [2*bit_width-1:0] w_im_x;
  logic                          r_valid;
  bin_t                          r_tag;
  mag_t                          r_sq_re;
  mag_t                          r_sq_im;

  assign w_re_x = {{bit_width{i_re[bit_width-1]}}, i_re};
  assign w_im_x = {{bit_width{i_im[bit_width-1]}}, i_im};

  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid <= 1'b0;
      r_tag   <= '0;
      r_sq_re <= '0;
      r_sq_im <= '0;
    end else begin
      r_valid <= i_valid;
      r_tag   <= i_tag;
      r_sq_re <= w_re_x * w_re_x;
      r_sq_im <= w_im_x * w_im_x;
    end
  end

  // Each square is at most 2^(2bw-2), so the sum never exceeds 2^(2bw-1).
  assign o_sum   = r_sq_re + r_sq_im;
  assign o_valid = r_valid;
  assign o_tag   = r_tag;
endmodule

// File: rtl/fft_peak_reader.sv
// rtl/fft_peak_reader.sv - sweeps FFT result bins after each done edge and reports the peak bin
module fft_peak_reader
  import fft_pkg::*;
(
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        fft_done,
  output logic [M-1:0]                rd_adr,
  input  logic signed [bit_width-1:0] rd_re,
  input  logic signed [bit_width-1:0] rd_im,
  output logic                        busy,
  output logic                        peak_valid,
  output logic [M-2:0]                peak_bin,
  output logic [2*bit_width-1:0]      peak_mag
);
  state_t r_state;
  state_t w_state_nxt;
  logic   r_done_q;
  adr_t   r_adr;
  logic   r_busy;
  logic   r_peak_valid;
  bin_t   r_peak_bin;
  mag_t   r_peak_mag;
  mag_t   r_best_mag;
  bin_t   r_best_bin;
  logic   r_lat_v   [RAM_LAT];
  bin_t   r_lat_tag [RAM_LAT];

  logic   w_trigger;
  logic   w_last_adr;
  logic   w_lat_busy;
  logic   w_sq_valid;
  bin_t   w_sq_tag;
  mag_t   w_sq_sum;
  mag_t   w_best_mag_nxt;
  bin_t   w_best_bin_nxt;

  assign w_trigger  = (r_state == IDLE) && fft_done && !r_done_q;
  assign w_last_adr = (r_adr == adr_t'(N/2-1));

  always_comb begin
    w_lat_busy = 1'b0;
    for (int i = 0; i < RAM_LAT; i++) w_lat_busy = w_lat_busy | r_lat_v[i];
  end

  mag_sq u_mag_sq (
    .clk     (clk),
    .reset   (reset),
    .i_valid (r_lat_v[RAM_LAT-1]),
    .i_tag   (r_lat_tag[RAM_LAT-1]),
    .i_re    (rd_re),
    .i_im    (rd_im),
    .o_valid (w_sq_valid),
    .o_tag   (w_sq_tag),
    .o_sum   (w_sq_sum)
  );

  // Strictly greater keeps the lowest bin on ties.
  always_comb begin
    w_best_mag_nxt = r_best_mag;
    w_best_bin_nxt = r_best_bin;
    if (w_sq_valid && (w_sq_sum > r_best_mag)) begin
      w_best_mag_nxt = w_sq_sum;
      w_best_bin_nxt = w_sq_tag;
    end
  end

  // DRAIN exits once nothing is waiting on the RAM; the sample in the squarer
  // is folded into the result through the next-best values on that same edge.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_trigger)   w_state_nxt = SWEEP;
      SWEEP:   if (w_last_adr)  w_state_nxt = DRAIN;
      DRAIN:   if (!w_lat_busy) w_state_nxt = DONE;
      DONE:                     w_state_nxt = IDLE;
      default:                  w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= IDLE;
      r_done_q     <= 1'b0;
      r_adr        <= '0;
      r_busy       <= 1'b0;
      r_peak_valid <= 1'b0;
      r_peak_bin   <= '0;
      r_peak_mag   <= '0;
      r_best_mag   <= '0;
      r_best_bin   <= bin_t'(MIN_BIN);
      for (int i = 0; i < RAM_LAT; i++) begin
        r_lat_v[i]   <= 1'b0;
        r_lat_tag[i] <= '0;
      end
    end else begin
      r_state      <= w_state_nxt;
      r_done_q     <= fft_done;
      r_peak_valid <= 1'b0;

      r_lat_v[0]   <= (r_state == SWEEP);
      r_lat_tag[0] <= r_adr[M-2:0];
      for (int i = 1; i < RAM_LAT; i++) begin
        r_lat_v[i]   <= r_lat_v[i-1];
        r_lat_tag[i] <= r_lat_tag[i-1];
      end

      if (w_trigger) begin
        r_best_mag <= '0;
        r_best_bin <= bin_t'(MIN_BIN);
      end else begin
        r_best_mag <= w_best_mag_nxt;
        r_best_bin <= w_best_bin_nxt;
      end

      case (r_state)
        IDLE: if (w_trigger) begin
          r_adr  <= adr_t'(MIN_BIN);
          r_busy <= 1'b1;
        end
        SWEEP: r_adr <= w_last_adr ? '0 : r_adr + 1'b1;
        DRAIN: if (!w_lat_busy) begin
          r_peak_bin   <= w_best_bin_nxt;
          r_peak_mag   <= w_best_mag_nxt;
          r_peak_valid <= 1'b1;
          r_busy       <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign rd_adr     = r_adr;
  assign busy       = r_busy;
  assign peak_valid = r_peak_valid;
  assign peak_bin   = r_peak_bin;
  assign peak_mag   = r_peak_mag;
endmodule
